// File: rtl/hsynth_i2s_tx_if.sv
// ---------------------------------------------------------------------------
// hsynth_i2s_tx_if
// Playback FIFO read interface between the I2S transmitter and a show-ahead
// FIFO.
//   fifo_empty  FIFO empty flag (FIFO -> transmitter)
//   fifo_rdata  FIFO head word {left, right}, valid while fifo_empty = 0
//   fifo_rd     one-clk pop strobe (transmitter -> FIFO)
// Modports: master = transmitter side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface hsynth_i2s_tx_if #(
   parameter int DATA_W = 24
) ();
   logic                  fifo_empty;
   logic [2*DATA_W-1:0]   fifo_rdata;
   logic                  fifo_rd;

   modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
   modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/hsynth_i2s_tx.sv
// ---------------------------------------------------------------------------
// hsynth_i2s_tx
// I2S playback serializer. Runs on clk, oversamples bclk/lrclk, pops one
// stereo pair per frame from a show-ahead FIFO and shifts it out MSB-first.
//
// Parameters:
//   DATA_W  sample width per channel (bits)
//   SLOT_W  bclk periods per half-frame slot (DATA_W <= SLOT_W <= 64)
//
// Ports:
//   clk, reset_n   system clock (>= 8x bclk), async active-low reset
//   enable         level; 0 returns the transmitter to idle
//   bclk, lrclk    asynchronous bit / word clocks (lrclk 0 = left)
//   fifo           playback FIFO read interface (master modport)
//   sdata          serial data to the codec
//   frame_start    one-clk pulse at each left-channel start while running
//   underrun       sticky flag, set when a frame starts on an empty FIFO
//   underrun_clr   clears underrun (set wins if both occur together)
//   fmt_lj         (HSYNTH_I2S_TX_LJ_EN only) 1 = left-justified format
//
// Optional feature macro: HSYNTH_I2S_TX_LJ_EN adds the fmt_lj input and
// left-justified mode. Without it the block is I2S only.
// ---------------------------------------------------------------------------
module hsynth_i2s_tx #(
   parameter int DATA_W = 24,
   parameter int SLOT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 bclk,
   input  logic                 lrclk,
   hsynth_i2s_tx_if.master      fifo,
   output logic                 sdata,
   output logic                 frame_start,
   output logic                 underrun,
`ifdef HSYNTH_I2S_TX_LJ_EN
   input  logic                 fmt_lj,
`endif
   input  logic                 underrun_clr
);

   localparam int PAD   = SLOT_W - DATA_W;
   localparam int CNT_W = $clog2(SLOT_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W);

   typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

   state_t                state, state_nx;

   logic                  bclk_m, bclk_s, bclk_d;
   logic                  lr_m, lr_s, lr_last;
   logic                  bf, bnd_fall, bnd_rise;

   logic                  load_frame, load_right, load_chan;
   logic                  running, lj_mode, next_bit;
   logic [2*DATA_W-1:0]   frame_data, hold;
   logic [SLOT_W-1:0]     sr, new_word;
   logic [CNT_W-1:0]      cnt;

   // Channel sample placed MSB-first in the slot, pad bits zero.
   function automatic logic [SLOT_W-1:0] slot_word(input logic [DATA_W-1:0] d);
      return SLOT_W'(d) << PAD;
   endfunction

   // ------------------------------------------------------------------
   // Synchronizers and bclk falling-edge / lrclk boundary detection
   // ------------------------------------------------------------------
   // NOTE: every flop gets the async reset, including wide data registers;
   // state elements use non-blocking assignments so all of them update
   // from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bclk_m  <= 1'b0;
         bclk_s  <= 1'b0;
         bclk_d  <= 1'b0;
         lr_m    <= 1'b0;
         lr_s    <= 1'b0;
         lr_last <= 1'b0;
      end else begin
         bclk_m <= bclk;
         bclk_s <= bclk_m;
         bclk_d <= bclk_s;
         lr_m   <= lrclk;
         lr_s   <= lr_m;
         // lrclk is only looked at on bclk falls, so a change between
         // falls is seen at the next one.
         if (bf) lr_last <= lr_s;
      end
   end

   assign bf       = bclk_d & ~bclk_s;
   assign bnd_fall = bf &  lr_last & ~lr_s;
   assign bnd_rise = bf & ~lr_last &  lr_s;

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // NOTE: every output of this block is given a default first so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx    = state;
      load_frame  = 1'b0;
      load_right  = 1'b0;
      if (!enable) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:  state_nx = SYNC;
            // Only a left start leaves SYNC, so a partial frame is never sent.
            SYNC:  if (bnd_fall) begin state_nx = LEFT;  load_frame = 1'b1; end
            LEFT:  if (bnd_rise) begin state_nx = RIGHT; load_right = 1'b1; end
            RIGHT: if (bnd_fall) begin state_nx = LEFT;  load_frame = 1'b1; end
            default: state_nx = IDLE;
         endcase
      end
      fifo.fifo_rd = load_frame & ~fifo.fifo_empty;
      frame_start  = load_frame;
   end

   assign running    = (state == LEFT) || (state == RIGHT);
   assign load_chan  = load_frame | load_right;
   assign frame_data = fifo.fifo_empty ? '0 : fifo.fifo_rdata;
   assign new_word   = load_frame ? slot_word(frame_data[2*DATA_W-1:DATA_W])
                                  : slot_word(hold[DATA_W-1:0]);
   // Past SLOT_W bits in one half-frame the line idles at 0.
   assign next_bit   = (cnt < CNT_MAX) ? sr[SLOT_W-1] : 1'b0;

   // ------------------------------------------------------------------
   // Format select: sampled only while not running
   // ------------------------------------------------------------------
`ifdef HSYNTH_I2S_TX_LJ_EN
   logic lj_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              lj_q <= 1'b0;
      else if (state == IDLE || state == SYNC)   lj_q <= fmt_lj;
   end
   assign lj_mode = lj_q;
`else
   assign lj_mode = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Hold / shift datapath, serial output and underrun flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold     <= '0;
         sr       <= '0;
         cnt      <= '0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         // Set has priority over a clear in the same cycle.
         underrun <= (load_frame & fifo.fifo_empty) | (underrun & ~underrun_clr);

         if (load_frame) hold <= frame_data;

         if (!enable) begin
            sdata <= 1'b0;
         end else if (bf) begin
            if (load_chan) begin
               if (lj_mode) begin
                  // Left-justified: the MSB goes out on the boundary fall
                  // itself, so one bit is already consumed.
                  sdata <= new_word[SLOT_W-1];
                  sr    <= new_word << 1;
                  cnt   <= CNT_W'(1);
               end else begin
                  // I2S: the boundary fall still carries the last bit of
                  // the previous slot; the new MSB follows one bclk later.
                  sdata <= running ? next_bit : 1'b0;
                  sr    <= new_word;
                  cnt   <= '0;
               end
            end else if (running) begin
               sdata <= next_bit;
               if (cnt < CNT_MAX) begin
                  sr  <= sr << 1;
                  cnt <= cnt + CNT_W'(1);
               end
            end else begin
               sdata <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_hsynth_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_hsynth_i2s_tx
// Directed bench for hsynth_i2s_tx: clk = 16x bclk. Serial data is captured
// at each rising bclk (the codec sampling point) and slots are rebuilt from
// the capture stream and compared with hand-computed words.
// ---------------------------------------------------------------------------
module tb_hsynth_i2s_tx;
   localparam int DATA_W = 24;
   localparam int SLOT_W = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic bclk = 1'b1;
   logic lrclk = 1'b1;
   logic underrun_clr = 1'b0;
   logic sdata, frame_start, underrun;
`ifdef HSYNTH_I2S_TX_LJ_EN
   logic fmt_lj = 1'b0;
`endif

   hsynth_i2s_tx_if #(.DATA_W(DATA_W)) fifo_if ();

   hsynth_i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .fifo         (fifo_if.master),
      .sdata        (sdata),
      .frame_start  (frame_start),
      .underrun     (underrun),
`ifdef HSYNTH_I2S_TX_LJ_EN
      .fmt_lj       (fmt_lj),
`endif
      .underrun_clr (underrun_clr)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   rd_cnt = 0;
   int   fs_cnt = 0;
   logic cap[$];

   always @(negedge clk) begin
      if (fifo_if.fifo_rd) rd_cnt++;
      if (frame_start)     fs_cnt++;
   end

   always @(posedge bclk) cap.push_back(sdata);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Drive n bclk periods with lrclk = lr changing on the falls; start is the
   // capture index of the first (boundary) fall of this half.
   task automatic send_half(input logic lr, input int n, output int start);
      start = cap.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bclk  = 1'b0;
         lrclk = lr;
         repeat (8) @(negedge clk);
         bclk = 1'b1;
         repeat (7) @(negedge clk);
      end
   endtask

   // Rebuild a slot of n bits, left-aligned in 64 bits. In I2S the slot
   // begins one fall after its boundary; in left-justified mode on it.
   function automatic logic [63:0] slot(input int start, input int n, input bit lj);
      logic [63:0] r;
      int idx;
      r = '0;
      for (int k = 0; k < n; k++) begin
         idx = lj ? start + k : start + 1 + k;
         r[63-k] = (idx < cap.size()) ? cap[idx] : 1'bx;
      end
      return r;
   endfunction

   typedef struct {
      logic [47:0] head;
      logic        empty;
      int          len;
      logic [63:0] exp_l;
      logic [63:0] exp_r;
      int          exp_rd;
      logic        exp_ur;
   } vec_t;

   vec_t vt[5];
   int   sl[5], sr[5], rd_d[5], fs_d[5];
   logic ur[5];

   initial begin
      int s0, s1, rd0, fs0, dummy;

      vt[0] = '{48'hABCDEF_123456, 1'b0, 32, 64'hABCDEF00_00000000, 64'h12345600_00000000, 1, 1'b0};
      vt[1] = '{48'hFFFFFF_FFFFFF, 1'b1, 32, 64'h0,                 64'h0,                 0, 1'b1};
      vt[2] = '{48'h800001_7FFFFE, 1'b0, 40, 64'h80000100_00000000, 64'h7FFFFE00_00000000, 1, 1'b1};
      vt[3] = '{48'hABCDEF_123456, 1'b0, 24, 64'hABCDEF00_00000000, 64'h12345600_00000000, 1, 1'b1};
      vt[4] = '{48'hFFFFFF_000001, 1'b0, 32, 64'hFFFFFF00_00000000, 64'h00000100_00000000, 1, 1'b1};

      fifo_if.fifo_empty = 1'b0;
      fifo_if.fifo_rdata = vt[0].head;
      enable = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_outputs", {60'h0, sdata, fifo_if.fifo_rd, frame_start, underrun}, 64'h0);
      reset_n = 1'b1;

      // Right half while syncing: no pop, no frame_start.
      send_half(1'b1, 32, dummy);
      check("sync_no_pop", 64'(rd_cnt), 64'd0);
      check("sync_no_fs",  64'(fs_cnt), 64'd0);

      // Table-driven frames.
      for (int i = 0; i < 5; i++) begin
         fifo_if.fifo_empty = vt[i].empty;
         fifo_if.fifo_rdata = vt[i].head;
         rd0 = rd_cnt;
         fs0 = fs_cnt;
         send_half(1'b0, vt[i].len, sl[i]);
         send_half(1'b1, vt[i].len, sr[i]);
         rd_d[i] = rd_cnt - rd0;
         fs_d[i] = fs_cnt - fs0;
         ur[i]   = underrun;
      end
      fifo_if.fifo_empty = 1'b0;
      fifo_if.fifo_rdata = vt[0].head;
      send_half(1'b0, 32, dummy);
      send_half(1'b1, 32, dummy);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("v%0d_left", i),  slot(sl[i], vt[i].len, 1'b0), vt[i].exp_l);
         check($sformatf("v%0d_right", i), slot(sr[i], vt[i].len, 1'b0), vt[i].exp_r);
         check($sformatf("v%0d_pops", i),  64'(rd_d[i]), 64'(vt[i].exp_rd));
         check($sformatf("v%0d_fs", i),    64'(fs_d[i]), 64'd1);
         check($sformatf("v%0d_ur", i),    64'(ur[i]),   64'(vt[i].exp_ur));
      end

      // Underrun held, then cleared one clk after underrun_clr.
      check("ur_held", 64'(underrun), 64'd1);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("ur_clear", 64'(underrun), 64'd0);

      // Enable dropped mid-left slot.
      fifo_if.fifo_rdata = 48'hFFFFFF_FFFFFF;
      rd0 = rd_cnt;
      send_half(1'b0, 10, dummy);
      check("en_pre_sdata", 64'(sdata), 64'd1);
      enable = 1'b0;
      @(negedge clk);
      check("en_drop_sdata", 64'(sdata), 64'd0);
      send_half(1'b0, 22, dummy);
      send_half(1'b1, 16, dummy);
      check("en_drop_pops", 64'(rd_cnt - rd0), 64'd1);
      // Re-enable mid right half: first pop only at the next left start.
      enable = 1'b1;
      fifo_if.fifo_rdata = 48'hA5A5A5_5A5A5A;
      rd0 = rd_cnt;
      send_half(1'b1, 16, dummy);
      check("reen_no_pop", 64'(rd_cnt - rd0), 64'd0);
      send_half(1'b0, 32, s0);
      send_half(1'b1, 32, s1);
      check("reen_pop", 64'(rd_cnt - rd0), 64'd1);
      check("reen_left", slot(s0, 32, 1'b0), 64'hA5A5A500_00000000);

      // Empty frame sets underrun again; then reset mid-frame.
      fifo_if.fifo_empty = 1'b1;
      send_half(1'b0, 32, dummy);
      check("reen_right", slot(s1, 32, 1'b0), 64'h5A5A5A00_00000000);
      send_half(1'b1, 32, dummy);
      check("ur_set_again", 64'(underrun), 64'd1);
      fifo_if.fifo_empty = 1'b0;
      fifo_if.fifo_rdata = 48'hFFFFFF_FFFFFF;
      send_half(1'b0, 10, dummy);
      check("rst_pre_sdata", 64'(sdata), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_outputs", {60'h0, sdata, fifo_if.fifo_rd, frame_start, underrun}, 64'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      fifo_if.fifo_rdata = 48'hC3C3C3_3C3C3C;
      rd0 = rd_cnt;
      send_half(1'b0, 22, dummy);
      send_half(1'b1, 32, dummy);
      check("rst_no_pop", 64'(rd_cnt - rd0), 64'd0);
      send_half(1'b0, 32, s0);
      send_half(1'b1, 32, s1);
      check("rst_pop", 64'(rd_cnt - rd0), 64'd1);
      send_half(1'b0, 2, dummy);
      check("rst_left",  slot(s0, 32, 1'b0), 64'hC3C3C300_00000000);
      check("rst_right", slot(s1, 32, 1'b0), 64'h3C3C3C00_00000000);
      check("rst_ur", 64'(underrun), 64'd0);

`ifdef HSYNTH_I2S_TX_LJ_EN
      // Left-justified: MSB on the boundary fall; fmt_lj ignored while running.
      fmt_lj = 1'b1;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      fifo_if.fifo_rdata = 48'hABCDEF_123456;
      send_half(1'b0, 30, dummy);
      send_half(1'b1, 32, dummy);
      send_half(1'b0, 32, s0);
      fmt_lj = 1'b0;
      send_half(1'b1, 32, s1);
      send_half(1'b0, 32, dummy);
      check("lj_left",  slot(s0, 32, 1'b1), 64'hABCDEF00_00000000);
      check("lj_right", slot(s1, 32, 1'b1), 64'h12345600_00000000);
      check("lj_msb_on_boundary", 64'(cap[s0]), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
